// File: rtl/serial_subtractor_32bit.sv
// Digit-serial subtractor: diff = in1 - in2 - b_in, DIGIT bits per clock,
// LSB digit first, borrow carried between cycles in a register.
// Optional feature macro: SUB_OVERFLOW_EN adds the registered ovf output
// (two's-complement signed overflow of the same subtraction).
// WIDTH is expected to be a multiple of DIGIT and larger than DIGIT.
//
// state | meaning
// IDLE  | waiting for start, result registers hold last value
// RUN   | one digit subtracted per clock, N clocks total
// DONE  | result just written, done high; start here chains a new operation
module serial_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             last_digit;
    logic [DIGIT:0]   stage;
    logic [DIGIT-1:0] dig;
    logic             dig_bo;

    // Operands are only accepted while not busy (IDLE or DONE).
    assign capture    = start && (state != RUN);
    assign last_digit = (state == RUN) && (cnt == '0);

    // One DIGIT-wide ripple-borrow stage on the current low digit.
    always_comb begin
        stage  = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow};
        dig    = stage[DIGIT-1:0];
        dig_bo = stage[DIGIT];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carried borrow and digit down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (capture) begin
            a_sh   <= in1;
            b_sh   <= in2;
            borrow <= b_in;
            cnt    <= CNT_LAST;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= {dig, res_sh[WIDTH-1:DIGIT]};
            borrow <= dig_bo;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // Visible result registers, written only on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff  <= '0;
            b_out <= 1'b0;
        end else if (last_digit) begin
            diff  <= {dig, res_sh[WIDTH-1:DIGIT]};
            b_out <= dig_bo;
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic msb_bin;

    // Borrow into the MSB recovered from the MSB sum bit: d = a ^ b ^ bin.
    assign msb_bin = stage[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];

    // Signed overflow = borrow into MSB differs from borrow out of MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_digit) begin
            ovf <= msb_bin ^ dig_bo;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Bench for serial_subtractor_32bit: a DIGIT=1 and a DIGIT=4 instance share
// the stimulus; a cycle-level arithmetic model is compared every cycle, and
// hand-computed results are checked at each completion.
module tb_serial_subtractor_32bit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        b_in  = 1'b0;
    logic [31:0] in1   = '0;
    logic [31:0] in2   = '0;

    logic [31:0] diff1, diff4;
    logic        bo1, bo4, busy1, busy4, done1, done4;
`ifdef SUB_OVERFLOW_EN
    logic        ovf1, ovf4;
`endif

    serial_subtractor_32bit #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
        .b_in(b_in), .diff(diff1), .b_out(bo1), .busy(busy1), .done(done1)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    serial_subtractor_32bit #(.WIDTH(32), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
        .b_in(b_in), .diff(diff4), .b_out(bo4), .busy(busy4), .done(done4)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_rem [2];
    logic [31:0] m_diff[2];
    logic        m_bo  [2];
    logic        m_ovf [2];
    logic        m_done[2];
    logic [31:0] m_pdiff[2];
    logic        m_pbo [2];
    logic        m_povf[2];
    int          m_cap [2];
    int          m_edge = 0;

    function automatic int n_of(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [32:0] t;
        longint      s;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_rem[i]  = 0;
                m_diff[i] = '0;
                m_bo[i]   = 1'b0;
                m_ovf[i]  = 1'b0;
                m_done[i] = 1'b0;
            end
        end else begin
            m_edge++;
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                if (m_rem[i] == 0) begin
                    if (start) begin
                        t = {1'b0, in1} - {1'b0, in2} - 33'(b_in);
                        s = longint'($signed(in1)) - longint'($signed(in2)) - longint'(b_in);
                        m_pdiff[i] = t[31:0];
                        m_pbo[i]   = t[32];
                        m_povf[i]  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                        m_rem[i]   = n_of(i);
                        m_cap[i]   = m_edge;
                    end
                end else begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_diff[i] = m_pdiff[i];
                        m_bo[i]   = m_pbo[i];
                        m_ovf[i]  = m_povf[i];
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- hand-computed expectations ----------------
    logic [31:0] lit_diff[16];
    logic        lit_bo  [16];
    logic        lit_chk [16];
    logic        lit_ov  [16];
    int          lit_wr  = 0;
    logic [31:0] lit4_diff = '0;
    logic        lit4_bo   = 1'b0;
    int          lit4_req  = 0;
    logic        end_req   = 1'b0;

    // ---------------- compare process ----------------
    int tests    = 0;
    int fails    = 0;
    int lit_rd   = 0;
    int lit4_ack = 0;

    always @(negedge clk) begin
        logic ov1_a, ov4_a;
`ifdef SUB_OVERFLOW_EN
        ov1_a = ovf1;
        ov4_a = ovf4;
`else
        ov1_a = m_ovf[0];
        ov4_a = m_ovf[1];
`endif
        tests++;
        if ({diff1, bo1, busy1, done1, ov1_a} !==
            {m_diff[0], m_bo[0], (m_rem[0] != 0), m_done[0], m_ovf[0]}) begin
            fails++;
            $display("FAIL cycle_d1 t=%0t got diff=%h b_out=%b busy=%b done=%b ovf=%b need diff=%h b_out=%b busy=%b done=%b ovf=%b",
                     $time, diff1, bo1, busy1, done1, ov1_a,
                     m_diff[0], m_bo[0], (m_rem[0] != 0), m_done[0], m_ovf[0]);
        end
        tests++;
        if ({diff4, bo4, busy4, done4, ov4_a} !==
            {m_diff[1], m_bo[1], (m_rem[1] != 0), m_done[1], m_ovf[1]}) begin
            fails++;
            $display("FAIL cycle_d4 t=%0t got diff=%h b_out=%b busy=%b done=%b ovf=%b need diff=%h b_out=%b busy=%b done=%b ovf=%b",
                     $time, diff4, bo4, busy4, done4, ov4_a,
                     m_diff[1], m_bo[1], (m_rem[1] != 0), m_done[1], m_ovf[1]);
        end
        if (done1) begin
            tests++;
            if (lit_rd >= lit_wr) begin
                fails++;
                $display("FAIL unexpected_done_d1 t=%0t got done=1 need done=0", $time);
            end else begin
                if (diff1 !== lit_diff[lit_rd] || bo1 !== lit_bo[lit_rd] ||
                    (m_edge - m_cap[0]) != 32 ||
                    (lit_chk[lit_rd] && ov1_a !== lit_ov[lit_rd])) begin
                    fails++;
                    $display("FAIL literal_d1_%0d got diff=%0d b_out=%b ovf=%b latency=%0d need diff=%0d b_out=%b ovf=%b latency=32",
                             lit_rd, diff1, bo1, ov1_a, m_edge - m_cap[0],
                             lit_diff[lit_rd], lit_bo[lit_rd], lit_ov[lit_rd]);
                end
                lit_rd++;
            end
        end
        if (done4 && lit4_ack != lit4_req) begin
            tests++;
            if (diff4 !== lit4_diff || bo4 !== lit4_bo || (m_edge - m_cap[1]) != 8) begin
                fails++;
                $display("FAIL literal_d4 got diff=%0d b_out=%b latency=%0d need diff=%0d b_out=%b latency=8",
                         diff4, bo4, m_edge - m_cap[1], lit4_diff, lit4_bo);
            end
            lit4_ack++;
        end
        if (end_req) begin
            tests++;
            if (lit_rd != lit_wr || lit4_ack != lit4_req) begin
                fails++;
                $display("FAIL completions got d1=%0d d4=%0d need d1=%0d d4=%0d",
                         lit_rd, lit4_ack, lit_wr, lit4_req);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic bo,
                        input logic chk, input logic ov);
        lit_diff[lit_wr] = d;
        lit_bo[lit_wr]   = bo;
        lit_chk[lit_wr]  = chk;
        lit_ov[lit_wr]   = ov;
        lit_wr++;
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic bi);
        in1   = a;
        in2   = b;
        b_in  = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        b_in  = 1'($urandom_range(1, 0));
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        rst_n = 1'b1;

        // start on the first edge after reset release
        push(32'd12365438, 1'b0, 1'b0, 1'b0);
        go(32'd111111110, 32'd98745672, 1'b0);
        repeat (34) tick();

        lit4_diff = 32'd98765678;
        lit4_bo   = 1'b0;
        lit4_req++;
        push(32'd98765678, 1'b0, 1'b0, 1'b0);
        go(32'd111111111, 32'd12345432, 1'b1);
        repeat (34) tick();

        push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        go(32'd0, 32'd1, 1'b0);
        repeat (34) tick();

        push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (34) tick();

        // start pulses at edges 5 and 10 of a running operation
        push(32'h1234_4567, 1'b0, 1'b0, 1'b0);
        go(32'h1234_5678, 32'h0000_1111, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            start = (k == 5 || k == 10);
            if (start) begin
                in1 = $urandom;
                in2 = $urandom;
            end
            tick();
        end
        start = 1'b0;

        // start held high through the run and the DONE cycle
        push(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
        push(32'hD2FF_CEE1, 1'b0, 1'b0, 1'b0);
        in1   = 32'h0000_0010;
        in2   = 32'h0000_0020;
        b_in  = 1'b0;
        start = 1'b1;
        tick();
        in1   = 32'hDEAD_BEEF;
        in2   = 32'h0BAD_F00D;
        b_in  = 1'b1;
        repeat (32) tick();
        tick();
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        repeat (34) tick();

        // reset between edges 10 and 11 of a run
        go(32'd7777, 32'd3333, 1'b0);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        push(32'd41, 1'b0, 1'b0, 1'b0);
        go(32'd100, 32'd58, 1'b1);
        repeat (34) tick();

        // signed overflow cases
        push(32'd2147483647, 1'b0, 1'b1, 1'b1);
        go(32'd2147483648, 32'd1, 1'b0);
        repeat (34) tick();
        push(32'd2, 1'b0, 1'b1, 1'b0);
        go(32'd5, 32'd3, 1'b0);
        repeat (34) tick();

        end_req = 1'b1;
        repeat (5) tick();
        $display("FAIL end_of_run got no summary need summary");
        $fatal(1, "bench did not terminate");
    end

endmodule

// File: doc/serial_subtractor_32bit.md
SERIAL_SUBTRACTOR_32BIT -- requirements
Module: serial_subtractor_32bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving bits processed per cycle; legal values are 1, 2, 4 and 8, and DIGIT SHALL divide WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, which requests an operation when high.
REQ-006 The block SHALL have ports in1 and in2, input, WIDTH bits each, holding the minuend and subtrahend.
REQ-007 The block SHALL have port b_in, input, 1 bit, the borrow-in.
REQ-008 The block SHALL have port diff, output, WIDTH bits, the registered difference.
REQ-009 The block SHALL have port b_out, output, 1 bit, the registered borrow-out.
REQ-010 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-012 The result SHALL be diff = (in1 - in2 - b_in) mod 2^WIDTH, and b_out = 1 iff in1 < in2 + b_in, both compared as unsigned.
REQ-013 Computation SHALL be digit-serial: a DIGIT-bit ripple-borrow stage processes one digit per cycle, LSB digit first, with the borrow registered between cycles.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after N = WIDTH/DIGIT digits; DONE->IDLE, or DONE->RUN if start is high.
REQ-015 start SHALL be sampled only when busy = 0 (IDLE or DONE); if start is high at edge E, the block SHALL capture in1, in2 and b_in internally at E.
REQ-016 busy SHALL be 1 after edge E through edge E+N-1 and 0 otherwise.
REQ-017 After edge E+N, diff and b_out SHALL hold the new result and done SHALL be 1 for exactly one cycle.
REQ-018 start asserted while busy = 1 SHALL be ignored with no effect on the operation in flight.
REQ-019 Input changes after the capture edge SHALL NOT affect the result.
REQ-020 diff and b_out SHALL change only at the completion edge and hold their value until the next completion.
REQ-021 start high in the DONE cycle SHALL begin a new operation back-to-back: done pulses at E+N and the next done at E+2N.

Reset
REQ-022 While rst_n = 0, the state SHALL be IDLE and diff, b_out, busy and done SHALL all be 0, plus ovf when present.
REQ-023 Reset asserted mid-operation SHALL abort it immediately, with no done pulse and no partial result visible.
REQ-024 After rst_n rises, the block SHALL accept start on the first rising edge.

Configuration
REQ-025 With macro SUB_OVERFLOW_EN defined, the block SHALL have an extra output ovf, 1 bit, registered with diff.
REQ-026 ovf SHALL equal the two's-complement signed overflow of in1 - in2 - b_in, computed from the final borrow into and out of the MSB.
REQ-027 Without SUB_OVERFLOW_EN, the ovf port and its logic SHALL be absent, and the behaviour of all other ports SHALL be unchanged.

Verification
REQ-028 With DIGIT = 1: in1 = 111111110, in2 = 98745672, b_in = 0, start at edge 0 -> diff = 12365438, b_out = 0, done high after edge 32 only, busy high after edges 0..31.
REQ-029 With DIGIT = 4: in1 = 111111111, in2 = 12345432, b_in = 1 -> diff = 98765678, b_out = 0, done after edge 8.
REQ-030 Wrap cases: in1 = 0, in2 = 1, b_in = 0 -> diff = 4294967295, b_out = 1; in1 = in2 = 4294967295, b_in = 1 -> diff = 4294967295, b_out = 1.
REQ-031 Handshake: start pulsed at edges 5 and 10 during an operation started at edge 0 -> ignored; start held high through the DONE cycle -> a second done exactly N cycles later; operand changes after capture leave the result unchanged.
REQ-032 Reset mid-operation: rst_n low between edges 10 and 11 of a run -> all outputs 0 asynchronously, no done pulse, and the next start produces the correct result.
REQ-033 With SUB_OVERFLOW_EN: in1 = 2147483648, in2 = 1, b_in = 0 -> diff = 2147483647, ovf = 1; in1 = 5, in2 = 3 -> ovf = 0.
